// File: rtl/render_cmd_queue_if.sv
// ---------------------------------------------------------------------------
// render_cmd_queue_if: Avalon-MM slave bus plus plot-engine command stream. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface render_cmd_queue_if #(
    parameter int X_W    = 9,
    parameter int Y_W    = 8,
    parameter int CODE_W = 8
);
    logic [3:0]        slave_address;
    logic              slave_read;
    logic              slave_write;
    logic [31:0]       slave_writedata;
    logic [31:0]       slave_readdata;
    logic              slave_waitrequest;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [X_W-1:0]    cmd_x;
    logic [Y_W-1:0]    cmd_y;
    logic [CODE_W-1:0] cmd_code;
    logic              engine_busy;

    modport slave (
        input  slave_address, slave_read, slave_write, slave_writedata,
        output slave_readdata, slave_waitrequest,
        output cmd_valid, cmd_x, cmd_y, cmd_code,
        input  cmd_ready, engine_busy
    );

    modport master (
        output slave_address, slave_read, slave_write, slave_writedata,
        input  slave_readdata, slave_waitrequest,
        input  cmd_valid, cmd_x, cmd_y, cmd_code,
        output cmd_ready, engine_busy
    );
endinterface

`default_nettype wire

// File: rtl/render_cmd_queue.sv
// ---------------------------------------------------------------------------
// render_cmd_queue: buffered register front-end queueing {code,x,y} plot commands.
// Option RENDER_CMDQ_DROP_EN: GO while full is dropped and flagged. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module render_cmd_queue #(
    parameter int X_W    = 9,
    parameter int Y_W    = 8,
    parameter int CODE_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    render_cmd_queue_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = CODE_W + X_W + Y_W;

    localparam logic [3:0] ADDR_STATUS = 4'd0;
    localparam logic [3:0] ADDR_X      = 4'd1;
    localparam logic [3:0] ADDR_Y      = 4'd2;
    localparam logic [3:0] ADDR_ISSUED = 4'd3;
    localparam logic [3:0] ADDR_CODE   = 4'd4;
    localparam logic [3:0] ADDR_GO     = 4'd6;

    logic [X_W-1:0]     x_reg;
    logic [Y_W-1:0]     y_reg;
    logic [CODE_W-1:0]  code_reg;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               overflow;
    logic [CNT_W-1:0]   issued;

    logic               go_write;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               ovf_set;
    logic               ovf_clr;
    logic [ENTRY_W-1:0] head;

    assign go_write = bus.slave_write && (bus.slave_address == ADDR_GO);
    assign empty    = (count == '0);
    assign full     = (count == (PTR_W+1)'(DEPTH));
    // Full is judged on the pre-edge count, so a same-cycle pop never lets a GO in.
    assign push     = go_write && !full;
    assign pop      = !empty && bus.cmd_ready;

`ifdef RENDER_CMDQ_DROP_EN
    assign bus.slave_waitrequest = 1'b0;
    assign ovf_set = go_write && full;
    assign ovf_clr = bus.slave_write && (bus.slave_address == ADDR_STATUS)
                     && bus.slave_writedata[3];
`else
    assign bus.slave_waitrequest = go_write && full;
    assign ovf_set = 1'b0;
    assign ovf_clr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_reg    <= '0;
            y_reg    <= '0;
            code_reg <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            issued   <= '0;
        end else begin
            if (bus.slave_write) begin
                case (bus.slave_address)
                    ADDR_X:    x_reg    <= bus.slave_writedata[X_W-1:0];
                    ADDR_Y:    y_reg    <= bus.slave_writedata[Y_W-1:0];
                    ADDR_CODE: code_reg <= bus.slave_writedata[CODE_W-1:0];
                    default:   ;
                endcase
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                issued <= issued + CNT_W'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (!push && pop) begin
                count <= count - (PTR_W+1)'(1);
            end
            // A new overflow outranks a simultaneous clear.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {code_reg, x_reg, y_reg};
        end
    end

    // Storage is not reset, so the head is masked while the queue is empty.
    assign head          = empty ? '0 : mem[rd_ptr];
    assign bus.cmd_valid = !empty;
    assign bus.cmd_code  = head[ENTRY_W-1 -: CODE_W];
    assign bus.cmd_x     = head[Y_W +: X_W];
    assign bus.cmd_y     = head[Y_W-1:0];

    always_comb begin
        bus.slave_readdata = '0;
        if (bus.slave_read && !bus.slave_waitrequest) begin
            case (bus.slave_address)
                ADDR_STATUS: begin
                    bus.slave_readdata[0]    = empty;
                    bus.slave_readdata[1]    = full;
                    bus.slave_readdata[2]    = empty && !bus.engine_busy;
                    bus.slave_readdata[3]    = overflow;
                    bus.slave_readdata[15:8] = 8'(count);
                end
                ADDR_X:      bus.slave_readdata[X_W-1:0]    = x_reg;
                ADDR_Y:      bus.slave_readdata[Y_W-1:0]    = y_reg;
                ADDR_CODE:   bus.slave_readdata[CODE_W-1:0] = code_reg;
                ADDR_ISSUED: bus.slave_readdata[CNT_W-1:0]  = issued;
                default:     bus.slave_readdata = '0;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_render_cmd_queue.sv
// ---------------------------------------------------------------------------
// tb_render_cmd_queue: directed and randomized checks against a queue-based model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_render_cmd_queue;
    localparam int X_W = 9, Y_W = 8, CODE_W = 8, DEPTH = 8, CNT_W = 16;
    localparam int ENTRY_W = CODE_W + X_W + Y_W;
`ifdef RENDER_CMDQ_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    render_cmd_queue_if #(.X_W(X_W), .Y_W(Y_W), .CODE_W(CODE_W)) bus ();

    render_cmd_queue #(.X_W(X_W), .Y_W(Y_W), .CODE_W(CODE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: register file plus a command queue.
    bit [ENTRY_W-1:0] mq[$];
    bit [X_W-1:0]     m_x;
    bit [Y_W-1:0]     m_y;
    bit [CODE_W-1:0]  m_code;
    bit [CNT_W-1:0]   m_issued;
    bit               m_ovf;
    int               m_sz;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_x = '0; m_y = '0; m_code = '0; m_issued = '0; m_ovf = 1'b0;
        end else begin
            m_sz = mq.size();
            if (bus.slave_write) begin
                case (bus.slave_address)
                    4'd1: m_x    = bus.slave_writedata[X_W-1:0];
                    4'd2: m_y    = bus.slave_writedata[Y_W-1:0];
                    4'd4: m_code = bus.slave_writedata[CODE_W-1:0];
                    4'd0: if (DROP && bus.slave_writedata[3]) m_ovf = 1'b0;
                    4'd6: begin
                        if (m_sz < DEPTH) mq.push_back({m_code, m_x, m_y});
                        else if (DROP) m_ovf = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (bus.cmd_ready && m_sz > 0) begin
                void'(mq.pop_front());
                m_issued = m_issued + 1'b1;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            4'd0: begin
                r[0]    = (mq.size() == 0);
                r[1]    = (mq.size() == DEPTH);
                r[2]    = (mq.size() == 0) && !bus.engine_busy;
                r[3]    = m_ovf;
                r[15:8] = 8'(mq.size());
            end
            4'd1: r[X_W-1:0]    = m_x;
            4'd2: r[Y_W-1:0]    = m_y;
            4'd3: r[CNT_W-1:0]  = m_issued;
            4'd4: r[CODE_W-1:0] = m_code;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.slave_address   = '0;
        bus.slave_read      = 1'b0;
        bus.slave_write     = 1'b0;
        bus.slave_writedata = '0;
        bus.cmd_ready       = 1'b0;
        bus.engine_busy     = 1'b0;
    endtask

    task automatic do_reset();
        idle_bus();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.slave_address   = a;
        bus.slave_writedata = d;
        bus.slave_write     = 1'b1;
        step();
        bus.slave_write     = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        bus.slave_address = a;
        bus.slave_read    = 1'b1;
        @(negedge clk);
        d = bus.slave_readdata;
        step();
        bus.slave_read    = 1'b0;
    endtask

    task automatic drain(input logic [CODE_W-1:0] want_last);
        logic [CODE_W-1:0] last;
        last = '0;
        bus.cmd_ready = 1'b1;
        for (int k = 0; k < DEPTH + 2; k++) begin
            @(negedge clk);
            if (mq.size() > 0) begin
                n_tests++;
                if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== mq[0][ENTRY_W-1 -: CODE_W]) begin
                    n_fail++;
                    $display("FAIL drain_head: valid=%0d code=%h want valid=1 code=%h",
                             bus.cmd_valid, bus.cmd_code, mq[0][ENTRY_W-1 -: CODE_W]);
                end
                last = bus.cmd_code;
            end
            step();
        end
        bus.cmd_ready = 1'b0;
        n_tests++;
        if (last !== want_last || bus.cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_last: last=%h valid=%0d want last=%h valid=0",
                     last, bus.cmd_valid, want_last);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        @(negedge clk);
        n_tests++;
        if (bus.cmd_valid !== 1'b0 || bus.slave_waitrequest !== 1'b0 || bus.slave_readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%0d wait=%0d rdata=%h want 0 0 0",
                     bus.cmd_valid, bus.slave_waitrequest, bus.slave_readdata);
        end
        n_tests++;
        if ({bus.cmd_code, bus.cmd_x, bus.cmd_y} !== '0) begin
            n_fail++;
            $display("FAIL reset_head: code=%h x=%h y=%h want 0", bus.cmd_code, bus.cmd_x, bus.cmd_y);
        end
        rd(4'd0, d);
        n_tests++;
        if (d !== 32'h0000_0005) begin
            n_fail++;
            $display("FAIL reset_status: got %h want 00000005", d);
        end
        rd(4'd3, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_issued: got %h want 0", d);
        end
    endtask

    task automatic test_single();
        logic [31:0] d;
        do_reset();
        wr(4'd1, 32'd20);
        wr(4'd2, 32'd20);
        wr(4'd4, 32'h01);
        bus.slave_address = 4'd6;
        bus.slave_write   = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency: valid=%0d before GO edge want 0", bus.cmd_valid);
        end
        step();
        bus.slave_write = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.cmd_valid !== 1'b1 || bus.cmd_x !== 9'd20 || bus.cmd_y !== 8'd20 || bus.cmd_code !== 8'h01) begin
            n_fail++;
            $display("FAIL single_head: valid=%0d x=%0d y=%0d code=%h want 1 20 20 01",
                     bus.cmd_valid, bus.cmd_x, bus.cmd_y, bus.cmd_code);
        end
        rd(4'd0, d);
        n_tests++;
        if (d[15:8] !== 8'd1 || d[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_count: status=%h want count=1 empty=0", d);
        end
        bus.cmd_ready = 1'b1;
        step();
        bus.cmd_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: valid=%0d want 0", bus.cmd_valid);
        end
        rd(4'd3, d);
        n_tests++;
        if (d !== 32'd1) begin
            n_fail++;
            $display("FAIL single_issued: got %0d want 1", d);
        end
    endtask

    task automatic test_full();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            wr(4'd4, 32'(i + 16));
            wr(4'd6, 32'h0);
        end
        rd(4'd0, d);
        n_tests++;
        if (d !== 32'h0000_0802) begin
            n_fail++;
            $display("FAIL full_status: got %h want 00000802", d);
        end
        wr(4'd4, 32'h99);
        bus.slave_address = 4'd6;
        bus.slave_write   = 1'b1;
`ifdef RENDER_CMDQ_DROP_EN
        @(negedge clk);
        n_tests++;
        if (bus.slave_waitrequest !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_nowait: wait=%0d want 0", bus.slave_waitrequest);
        end
        step();
        bus.slave_write = 1'b0;
        rd(4'd0, d);
        n_tests++;
        if (d !== 32'h0000_080A) begin
            n_fail++;
            $display("FAIL drop_status: got %h want 0000080a", d);
        end
        wr(4'd0, 32'h8);
        rd(4'd0, d);
        n_tests++;
        if (d !== 32'h0000_0802) begin
            n_fail++;
            $display("FAIL drop_clear: got %h want 00000802", d);
        end
        drain(8'h17);
`else
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.slave_waitrequest !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_wait: cycle %0d wait=%0d want 1", k, bus.slave_waitrequest);
            end
            step();
        end
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.slave_waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_no_bypass: wait=%0d want 1", bus.slave_waitrequest);
        end
        step();
        bus.cmd_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.slave_waitrequest !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: wait=%0d want 0", bus.slave_waitrequest);
        end
        step();
        bus.slave_write = 1'b0;
        rd(4'd0, d);
        n_tests++;
        if (d !== 32'h0000_0802) begin
            n_fail++;
            $display("FAIL stall_retired: got %h want 00000802", d);
        end
        drain(8'h99);
`endif
    endtask

    task automatic test_order();
        logic [31:0] d;
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            wr(4'd4, 32'(c));
            wr(4'd6, 32'h0);
        end
        bus.cmd_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 8'(k)) begin
                n_fail++;
                $display("FAIL order_code: valid=%0d code=%0d want 1 %0d", bus.cmd_valid, bus.cmd_code, k);
            end
            step();
        end
        bus.cmd_ready = 1'b0;
        rd(4'd3, d);
        n_tests++;
        if (d !== 32'd5 || bus.cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL order_issued: issued=%0d valid=%0d want 5 0", d, bus.cmd_valid);
        end
    endtask

    task automatic test_truncate();
        logic [31:0] d;
        do_reset();
        wr(4'd1, 32'h0001_0159);
        wr(4'd2, 32'h0000_01EF);
        wr(4'd6, 32'h0);
        @(negedge clk);
        n_tests++;
        if (bus.cmd_x !== 9'h159 || bus.cmd_y !== 8'hEF) begin
            n_fail++;
            $display("FAIL trunc_head: x=%h y=%h want 159 ef", bus.cmd_x, bus.cmd_y);
        end
        wr(4'd9, 32'hFFFF_FFFF);
        rd(4'd9, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL trunc_addr9: got %h want 0", d);
        end
        rd(4'd1, d);
        n_tests++;
        if (d !== 32'h159) begin
            n_fail++;
            $display("FAIL trunc_xreg: got %h want 159", d);
        end
    endtask

    task automatic test_random();
        logic [3:0] waddrs [6];
        bit         stalled;
        bit         exp_wait;
        int         op;
        waddrs = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd9, 4'd3};
        stalled = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.cmd_ready   = (cyc < 200) ? ($urandom % 8 == 0) : ($urandom % 2 == 0);
            bus.engine_busy = ($urandom % 2 == 0);
            if (!stalled) begin
                bus.slave_read  = 1'b0;
                bus.slave_write = 1'b0;
                op = $urandom % 4;
                if (op == 1) begin
                    bus.slave_write     = 1'b1;
                    bus.slave_address   = waddrs[$urandom % 6];
                    bus.slave_writedata = $urandom;
                end else if (op == 2) begin
                    bus.slave_read    = 1'b1;
                    bus.slave_address = 4'($urandom);
                end else if (op == 3) begin
                    bus.slave_write     = 1'b1;
                    bus.slave_address   = 4'd6;
                    bus.slave_writedata = $urandom;
                end
            end
            @(negedge clk);
            exp_wait = !DROP && bus.slave_write && bus.slave_address == 4'd6 && mq.size() == DEPTH;
            n_tests++;
            if (bus.slave_waitrequest !== exp_wait || bus.cmd_valid !== (mq.size() > 0)) begin
                n_fail++;
                $display("FAIL rand_ctrl: cyc %0d wait=%0d valid=%0d want %0d %0d",
                         cyc, bus.slave_waitrequest, bus.cmd_valid, exp_wait, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                n_tests++;
                if ({bus.cmd_code, bus.cmd_x, bus.cmd_y} !== mq[0]) begin
                    n_fail++;
                    $display("FAIL rand_head: cyc %0d got %h want %h",
                             cyc, {bus.cmd_code, bus.cmd_x, bus.cmd_y}, mq[0]);
                end
            end
            if (bus.slave_read) begin
                n_tests++;
                if (bus.slave_readdata !== exp_rd(bus.slave_address)) begin
                    n_fail++;
                    $display("FAIL rand_read: cyc %0d addr %0d got %h want %h",
                             cyc, bus.slave_address, bus.slave_readdata, exp_rd(bus.slave_address));
                end
            end
            stalled = exp_wait;
            step();
        end
        idle_bus();
    endtask

    initial begin
        idle_bus();
        test_reset();
        test_single();
        test_full();
        test_order();
        test_truncate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
